// File: rtl/oser_pattern_gen.sv
// Multi-channel soft serializer with built-in pattern source (ALT/WALK/PRBS7/COUNT/EXT).
// One bit per clk_i edge, RATIO bits per frame per channel, LSB first.
module oser_pattern_gen #(
   parameter int unsigned CH       = 4,
   parameter int unsigned RATIO    = 8,
   parameter bit          IDLE_LVL = 1'b0
) (
   input  logic                clk_i,
   input  logic                nrst_i,
   input  logic                en_i,
   input  logic [2:0]          mode_i,
   input  logic [CH*RATIO-1:0] data_i,
   input  logic                data_valid_i,
   output logic                data_ready_o,
   input  logic                clr_i,
   output logic [CH-1:0]       q_o,
   output logic                oe_o,
   output logic                pclk_o,
   output logic                frame_o,
   output logic                underrun_o
);

   localparam int unsigned      BW     = (RATIO > 2) ? $clog2(RATIO) : 1;
   localparam logic [BW-1:0]    BMax   = BW'(RATIO - 1);
   localparam logic [BW-1:0]    BHalf  = BW'(RATIO / 2);
   localparam logic [RATIO-1:0] OneW   = {{(RATIO-1){1'b0}}, 1'b1};
   localparam logic [RATIO-1:0] IdleW  = {RATIO{IDLE_LVL}};
   localparam logic [RATIO-1:0] AltW   = {(RATIO/2){2'b10}};

   localparam logic [2:0] ModeAlt   = 3'd0;
   localparam logic [2:0] ModeWalk  = 3'd1;
   localparam logic [2:0] ModePrbs  = 3'd2;
   localparam logic [2:0] ModeCount = 3'd3;
   localparam logic [2:0] ModeExt   = 3'd4;

   logic [BW-1:0]              bcnt_q, bcnt_d;
   logic [15:0]                fcnt_q;
   logic                       boundary, run, ext_req;
   logic [CH-1:0][RATIO-1:0]   word, sr_q, prbs_word;
   logic [CH-1:0][6:0]         lfsr_q, lfsr_adv;
   logic [CH-1:0]              q_q;
   logic                       oe_q, pclk_q, frame_q, underrun_q;

   assign boundary     = (bcnt_q == BMax);
   assign bcnt_d       = boundary ? '0 : bcnt_q + 1'b1;
   assign run          = en_i && (mode_i <= ModeExt);
   assign ext_req      = boundary && en_i && (mode_i == ModeExt);
   assign data_ready_o = ext_req;

   // Unrolled PRBS7: word bit k is the output taken before step k.
   always_comb begin
      lfsr_adv  = lfsr_q;
      prbs_word = '0;
      for (int c = 0; c < int'(CH); c++) begin
         for (int k = 0; k < int'(RATIO); k++) begin
            prbs_word[c][k] = lfsr_adv[c][6];
            lfsr_adv[c]     = {lfsr_adv[c][5:0], lfsr_adv[c][6] ^ lfsr_adv[c][5]};
         end
      end
   end

   always_comb begin
      word = '0;
      for (int c = 0; c < int'(CH); c++) begin
         if (!run) begin
            word[c] = IdleW;
         end else begin
            case (mode_i)
               ModeAlt:   word[c] = AltW;
               ModeWalk:  word[c] = OneW << ((32'(fcnt_q) + unsigned'(c)) % RATIO);
               ModePrbs:  word[c] = prbs_word[c];
               ModeCount: word[c] = fcnt_q[RATIO-1:0];
               ModeExt:   word[c] = data_valid_i ? data_i[c*RATIO +: RATIO] : '0;
               default:   word[c] = IdleW;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         bcnt_q     <= '0;
         fcnt_q     <= '0;
         sr_q       <= {CH{IdleW}};
         q_q        <= {CH{IDLE_LVL}};
         oe_q       <= 1'b0;
         pclk_q     <= 1'b0;
         frame_q    <= 1'b0;
         underrun_q <= 1'b0;
         for (int c = 0; c < int'(CH); c++) begin
            lfsr_q[c] <= 7'(c + 1);
         end
      end else begin
         bcnt_q  <= bcnt_d;
         pclk_q  <= (bcnt_d < BHalf);
         frame_q <= (bcnt_d == '0);
         if (boundary) begin
            oe_q <= run;
            for (int c = 0; c < int'(CH); c++) begin
               q_q[c]  <= word[c][0];
               sr_q[c] <= {IDLE_LVL, word[c][RATIO-1:1]};
            end
            if (run) begin
               fcnt_q <= fcnt_q + 16'd1;
            end
            if (run && (mode_i == ModePrbs)) begin
               lfsr_q <= lfsr_adv;
            end
         end else begin
            for (int c = 0; c < int'(CH); c++) begin
               q_q[c]  <= sr_q[c][0];
               sr_q[c] <= {IDLE_LVL, sr_q[c][RATIO-1:1]};
            end
         end
         // A new underrun wins over a simultaneous clear.
         if (ext_req && !data_valid_i) begin
            underrun_q <= 1'b1;
         end else if (clr_i) begin
            underrun_q <= 1'b0;
         end
      end
   end

   assign q_o        = q_q;
   assign oe_o       = oe_q;
   assign pclk_o     = pclk_q;
   assign frame_o    = frame_q;
   assign underrun_o = underrun_q;

endmodule
